// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment definitions. Holds the active-low segment
//                patterns (bit 0 = a ... bit 6 = g), the blank code and the
//                capture FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Active-low patterns: a 0 bit lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Code reported for a dark digit; also the reset value of every slice.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Settling tracker states.
    typedef enum logic [1:0] {
        CHANGING = 2'd0,  // sample just differed from the previous one
        COUNT    = 2'd1,  // repeats seen, waiting for the settle threshold
        DONE     = 2'd2   // captured once, idle until the bus moves again
    } state_t;

    // True when exactly one bit is set; strobes are at most 8 wide.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational active-low 7-segment pattern to digit decoder.
//                Recognises 0..9 and blank; anything else is flagged invalid.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_leds,
    output logic       o_ok,
    output logic [3:0] o_code
);

    // Pattern lookup; invalid patterns report blank code with o_ok low.
    always_comb begin
        o_ok   = 1'b1;
        o_code = BLANK_CODE;
        case (i_leds)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = BLANK_CODE;
            default: begin
                o_ok   = 1'b0;
                o_code = BLANK_CODE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_frame_decoder
//  Description : Watches a multiplexed active-low 7-segment scan bus, waits for
//                each {strobe, pattern} pair to settle, decodes it into a
//                per-position 4-bit code and signals complete frames.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,  // multiplexed digit positions, 1..8
    parameter int STABLE = 3   // identical samples required before capture, 2..15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          leds,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   bcd,
    output logic [NDIG-1:0]     digit_ok,
    output logic                frame_valid,
    output logic                err
);

    localparam int         c_sample_w = NDIG + 7;
    localparam logic [3:0] c_stable   = 4'(STABLE);

    // Sampled bus and settle tracking.
    logic [c_sample_w-1:0] r_sample;
    logic [3:0]            r_cnt;
    state_t                r_state;
    state_t                w_state_next;
    logic [c_sample_w-1:0] w_new;
    logic                  w_same;
    logic                  w_capture;

    // Capture path.
    logic [NDIG-1:0]       w_cap_sel;
    logic [6:0]            w_cap_leds;
    logic                  w_dec_ok;
    logic [3:0]            w_dec_code;
    logic                  w_onehot;
    logic                  w_zero;
    logic [NDIG-1:0]       w_mask_next;

    // Output and frame bookkeeping registers.
    logic [4*NDIG-1:0]     r_bcd;
    logic [NDIG-1:0]       r_digit_ok;
    logic [NDIG-1:0]       r_mask;
    logic                  r_frame_valid;
    logic                  r_err;

    assign w_new  = {dig_sel, leds};
    assign w_same = (w_new == r_sample);

    // Register the bus every cycle; r_cnt counts identical samples held so far.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '0;
            r_cnt    <= 4'd0;
        end else begin
            r_sample <= w_new;
            if (!w_same) begin
                r_cnt <= 4'd1;
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Settle tracker state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CHANGING;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and capture strobe; a moving bus always restarts tracking.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            CHANGING: begin
                if (w_same) begin
                    w_state_next = COUNT;
                end
            end
            COUNT: begin
                // The held sample has been seen STABLE times: take it once.
                if (r_cnt == c_stable) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = CHANGING;
            end
        endcase
        if (!w_same) begin
            w_state_next = CHANGING;
        end
    end

    // The capture always uses the settled sample, never the live bus.
    assign w_cap_sel   = r_sample[c_sample_w-1:7];
    assign w_cap_leds  = r_sample[6:0];
    assign w_onehot    = is_onehot(8'(w_cap_sel));
    assign w_zero      = (w_cap_sel == '0);
    assign w_mask_next = r_mask | w_cap_sel;

    seg7_decode u_decode (
        .i_leds (w_cap_leds),
        .o_ok   (w_dec_ok),
        .o_code (w_dec_code)
    );

    // Apply a capture to the digit slices, validity bits and frame mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd         <= '1;
            r_digit_ok    <= '0;
            r_mask        <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            if (w_capture) begin
                if (w_onehot) begin
                    if (w_dec_ok) begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (w_cap_sel[i]) begin
                                r_bcd[4*i +: 4] <= w_dec_code;
                            end
                        end
                        r_digit_ok <= r_digit_ok | w_cap_sel;
                        // Last missing position completes the frame.
                        if (&w_mask_next) begin
                            r_frame_valid <= 1'b1;
                            r_mask        <= '0;
                        end else begin
                            r_mask <= w_mask_next;
                        end
                    end else begin
                        // Unknown pattern: keep old code, drop its validity.
                        r_err      <= 1'b1;
                        r_digit_ok <= r_digit_ok & ~w_cap_sel;
                    end
                end else if (!w_zero) begin
                    // Several strobes at once cannot be attributed to a digit.
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bcd         = r_bcd;
    assign digit_ok    = r_digit_ok;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_frame_decoder
//  Description : Self-checking bench for seg7_frame_decoder: directed scenarios
//                followed by random bus activity against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_frame_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  leds;
    logic [3:0]  dig_sel;
    logic [15:0] bcd;
    logic [3:0]  digit_ok;
    logic        frame_valid;
    logic        err;

    always #5 clk = ~clk;

    seg7_frame_decoder #(
        .NDIG   (NDIG),
        .STABLE (STABLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .leds        (leds),
        .dig_sel     (dig_sel),
        .bcd         (bcd),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int fv_seen  = 0;
    int err_seen = 0;

    // Digit patterns 0..9, index 10 = blank.
    logic [6:0] pats [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b1111111};

    // Reference model state.
    logic [10:0] hist [$];
    logic [15:0] m_bcd  = 16'hFFFF;
    logic [3:0]  m_ok   = 4'h0;
    logic [3:0]  m_mask = 4'h0;
    logic        m_fv   = 1'b0;
    logic        m_err  = 1'b0;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 11; i++) begin
            if (pats[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a settled {strobe, pattern} does to the display image.
    task automatic apply_capture(input logic [10:0] s);
        logic [3:0] sel;
        logic [6:0] seg;
        int         c;
        int         idx;
        sel = s[10:7];
        seg = s[6:0];
        c   = lookup(seg);
        idx = 0;
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            if (c >= 0) begin
                m_bcd[4*idx +: 4] = (c == 10) ? 4'hF : 4'(c);
                m_ok[idx]   = 1'b1;
                m_mask[idx] = 1'b1;
                if (m_mask == 4'hF) begin
                    m_fv   = 1'b1;
                    m_mask = 4'h0;
                end
            end else begin
                m_err     = 1'b1;
                m_ok[idx] = 1'b0;
            end
        end else if (sel != 4'h0) begin
            m_err = 1'b1;
        end
    endtask

    // One clock edge of the model: capture when the last STABLE samples form
    // a run of identical values that has just reached exactly that length.
    task automatic model_edge(input logic rst_in, input logic [10:0] s);
        int n;
        bit run;
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (rst_in) begin
            hist.delete();
            m_bcd  = 16'hFFFF;
            m_ok   = 4'h0;
            m_mask = 4'h0;
        end else begin
            n = hist.size();
            if (n >= STABLE) begin
                run = 1'b1;
                for (int k = n - STABLE; k < n; k++) begin
                    if (hist[k] != hist[n-1]) run = 1'b0;
                end
                if (run && (n == STABLE || hist[n-STABLE-1] != hist[n-1])) begin
                    apply_capture(hist[n-1]);
                end
            end
            hist.push_back(s);
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
        end
    endtask

    task automatic step(input logic rst_in, input logic [3:0] sel, input logic [6:0] seg);
        reset   = rst_in;
        dig_sel = sel;
        leds    = seg;
        @(posedge clk);
        model_edge(rst_in, {sel, seg});
        #1;
        if (frame_valid === 1'b1) fv_seen = fv_seen + 1;
        if (err === 1'b1) err_seen = err_seen + 1;
        chk("model_bcd", 32'(bcd), 32'(m_bcd));
        chk("model_digit_ok", 32'(digit_ok), 32'(m_ok));
        chk("model_frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("model_err", 32'(err), 32'(m_err));
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) step(1'b0, sel, seg);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [3:0] rsel;
        logic [6:0] rseg;
        int         len;
        int         kind;

        reset   = 1'b1;
        dig_sel = 4'h0;
        leds    = 7'h7F;

        // Reset for two cycles.
        step(1'b1, 4'h0, 7'h7F);
        step(1'b1, 4'h0, 7'h7F);
        chk("reset_bcd", 32'(bcd), 32'hFFFF);
        chk("reset_ok", 32'(digit_ok), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        chk("reset_err", 32'(err), 32'h0);

        // Single capture: "2" on digit 0, visible after the 4th sampling edge.
        fv_seen = 0;
        hold(4'b0001, 7'b0100100, 3);
        chk("single_before", 32'(bcd[3:0]), 32'hF);
        hold(4'b0001, 7'b0100100, 1);
        chk("single_code", 32'(bcd[3:0]), 32'h2);
        chk("single_ok", 32'(digit_ok), 32'h1);
        hold(4'b0001, 7'b0100100, 9);
        chk("single_hold", 32'(bcd), 32'hFFF2);
        chk("single_nofv", 32'(fv_seen), 32'h0);

        // Full frame 1, 9, 0, 7.
        fv_seen = 0;
        hold(4'b0001, 7'b1111001, 4);
        hold(4'b0010, 7'b0010000, 4);
        hold(4'b0100, 7'b1000000, 4);
        hold(4'b1000, 7'b1111000, 3);
        chk("frame_early", 32'(fv_seen), 32'h0);
        hold(4'b1000, 7'b1111000, 1);
        chk("frame_pulse", 32'(frame_valid), 32'h1);
        chk("frame_bcd", 32'(bcd), 32'h7091);
        chk("frame_ok", 32'(digit_ok), 32'hF);
        hold(4'b1000, 7'b1111000, 1);
        chk("frame_once", 32'(fv_seen), 32'h1);

        // Glitch restarts the settle window.
        step(1'b0, 4'b0100, 7'b0000000);
        step(1'b0, 4'b0100, 7'b0000001);
        hold(4'b0100, 7'b0000000, 3);
        chk("glitch_wait", 32'(bcd[11:8]), 32'h0);
        hold(4'b0100, 7'b0000000, 1);
        chk("glitch_cap", 32'(bcd[11:8]), 32'h8);

        // Invalid pattern on digit 1.
        err_seen = 0;
        hold(4'b0010, 7'b1010101, 3);
        step(1'b0, 4'b0000, 7'b1111111);
        chk("bad_err", 32'(err), 32'h1);
        chk("bad_ok1", 32'(digit_ok[1]), 32'h0);
        chk("bad_keep", 32'(bcd[7:4]), 32'h9);
        // Multi-hot strobe.
        hold(4'b0011, 7'b0010010, 5);
        chk("multi_err", 32'(err_seen), 32'h2);
        chk("multi_keep", 32'(bcd), 32'h7891);
        // Blanking interval.
        hold(4'b0000, 7'b0110000, 5);
        chk("zero_noerr", 32'(err_seen), 32'h2);

        // Reset mid-frame discards the partial mask.
        step(1'b1, 4'h0, 7'h7F);
        step(1'b1, 4'h0, 7'h7F);
        hold(4'b0001, 7'b0110000, 4);
        hold(4'b0010, 7'b0011001, 4);
        step(1'b1, 4'h0, 7'h7F);
        fv_seen = 0;
        hold(4'b0100, 7'b0010010, 4);
        hold(4'b1000, 7'b0000010, 4);
        chk("rst_partial", 32'(fv_seen), 32'h0);
        hold(4'b0001, 7'b0110000, 4);
        hold(4'b0010, 7'b0011001, 4);
        chk("rst_refill", 32'(fv_seen), 32'h1);
        chk("rst_bcd", 32'(bcd), 32'h6543);

        // Random bus activity.
        for (int it = 0; it < 200; it++) begin
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                step(1'b1, 4'(($urandom)), 7'($urandom));
            end else begin
                if (kind < 14)      rsel = 4'(1 << $urandom_range(0, 3));
                else if (kind < 16) rsel = 4'h0;
                else                rsel = 4'($urandom);
                if ($urandom_range(0, 3) == 0) rseg = 7'($urandom);
                else                           rseg = pats[$urandom_range(0, 10)];
                len = int'($urandom_range(1, 6));
                hold(rsel, rseg, len);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
